// File: rtl/uart_loader.sv
// Host-to-RAM program loader: decodes LOAD/GO frames from the UART RX byte stream,
// writes program bytes to the RAM write port and launches the CPU. Optional macro LOADER_ACK_EN adds a K/E acknowledge.
module uart_loader #(
  parameter int          ADDR_W   = 9,
  parameter int          TIMEOUT  = 1200000,
  parameter logic [7:0]  CMD_LOAD = 8'h4C,
  parameter logic [7:0]  CMD_GO   = 8'h47
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  input  logic              cpu_busy,
  output logic [ADDR_W-1:0] c_waddr,
  output logic [7:0]        dwrite,
  output logic              write_en,
  output logic [ADDR_W-1:0] startaddr,
  output logic              cpu_start,
  output logic              busy,
`ifdef LOADER_ACK_EN
  output logic [7:0]        tx_byte,
  output logic              transmit,
  input  logic              is_transmitting,
`endif
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE, L_AH, L_AL, L_LEN, DATA, CSUM, G_AH, G_AL
`ifdef LOADER_ACK_EN
    , ACK
`endif
  } state_t;

`ifdef LOADER_ACK_EN
  localparam state_t FRAME_END = ACK;
`else
  localparam state_t FRAME_END = IDLE;
`endif

  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                ah_q, ah_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [7:0]          sum_q, sum_d;
  logic [23:0]         tmo_q, tmo_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic                go_q, go_d;
  logic                err_q, err_d;
  logic                count_en;
`ifdef LOADER_ACK_EN
  logic                ack_bad_q, ack_bad_d;
  logic [7:0]          tx_q, tx_d;
  logic                txv_q, txv_d;
`endif

  // The inter-byte timer only runs while a frame is partially received.
  assign count_en = (state_q != IDLE)
`ifdef LOADER_ACK_EN
                    && (state_q != ACK)
`endif
                    ;

  always_comb begin
    state_d = state_q;
    ah_d    = ah_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    start_d = start_q;
    go_d    = 1'b0;
    err_d   = err_q;
`ifdef LOADER_ACK_EN
    ack_bad_d = ack_bad_q;
    tx_d      = tx_q;
    txv_d     = 1'b0;
`endif
    case (state_q)
      IDLE: if (rx_valid) begin
        if (rx_byte == CMD_LOAD) begin
          state_d = L_AH;
          err_d   = 1'b0;
        end else if (rx_byte == CMD_GO) begin
          state_d = G_AH;
          err_d   = 1'b0;
        end
      end
      L_AH: if (rx_valid) begin
        ah_d    = rx_byte[0];
        state_d = L_AL;
      end
      L_AL: if (rx_valid) begin
        addr_d  = ADDR_W'({ah_q, rx_byte});
        state_d = L_LEN;
      end
      L_LEN: if (rx_valid) begin
        cnt_d   = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
        sum_d   = 8'd0;
        state_d = DATA;
      end
      DATA: if (rx_valid) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = rx_byte;
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 9'd1;
        sum_d   = sum_q + rx_byte;
        if (cnt_q == 9'd1) state_d = CSUM;
      end
      CSUM: if (rx_valid) begin
        if (rx_byte != sum_q) err_d = 1'b1;
`ifdef LOADER_ACK_EN
        ack_bad_d = (rx_byte != sum_q);
`endif
        state_d = FRAME_END;
      end
      G_AH: if (rx_valid) begin
        ah_d    = rx_byte[0];
        state_d = G_AL;
      end
      G_AL: if (rx_valid) begin
        if (!cpu_busy) begin
          start_d = ADDR_W'({ah_q, rx_byte});
          go_d    = 1'b1;
        end else begin
          err_d = 1'b1;
        end
`ifdef LOADER_ACK_EN
        ack_bad_d = cpu_busy;
`endif
        state_d = FRAME_END;
      end
`ifdef LOADER_ACK_EN
      ACK: if (!is_transmitting) begin
        tx_d    = ack_bad_q ? 8'h45 : 8'h4B;
        txv_d   = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (count_en && !rx_valid && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
    tmo_d = (rx_valid || !count_en || state_d == IDLE) ? 24'd0 : tmo_q + 24'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ah_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      start_q <= '0;
      go_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_ACK_EN
      ack_bad_q <= 1'b0;
      tx_q      <= '0;
      txv_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ah_q    <= ah_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      start_q <= start_d;
      go_q    <= go_d;
      err_q   <= err_d;
`ifdef LOADER_ACK_EN
      ack_bad_q <= ack_bad_d;
      tx_q      <= tx_d;
      txv_q     <= txv_d;
`endif
    end
  end

  assign c_waddr   = waddr_q;
  assign dwrite    = wdata_q;
  assign write_en  = we_q;
  assign startaddr = start_q;
  assign cpu_start = go_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
`ifdef LOADER_ACK_EN
  assign tx_byte   = tx_q;
  assign transmit  = txv_q;
`endif

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: stimulus pushes expected RAM writes / CPU starts / acks,
// a forked monitor pops and compares them whenever the DUT strobes an output.
module tb_uart_loader;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cpu_busy = 1'b0;
  logic [8:0] c_waddr;
  logic [7:0] dwrite;
  logic       write_en;
  logic [8:0] startaddr;
  logic       cpu_start;
  logic       busy;
  logic       err;
`ifdef LOADER_ACK_EN
  logic [7:0] tx_byte;
  logic       transmit;
  logic       is_transmitting = 1'b0;
`endif

  uart_loader #(.ADDR_W(9), .TIMEOUT(TMO), .CMD_LOAD(8'h4C), .CMD_GO(8'h47)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .cpu_busy(cpu_busy),
    .c_waddr(c_waddr), .dwrite(dwrite), .write_en(write_en), .startaddr(startaddr),
    .cpu_start(cpu_start), .busy(busy),
`ifdef LOADER_ACK_EN
    .tx_byte(tx_byte), .transmit(transmit), .is_transmitting(is_transmitting),
`endif
    .err(err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; int at; } ev_t;
  typedef logic [7:0] bq_t [$];

  ev_t wq[$];
  ev_t sq[$];
  int  txq[$];
  int  total = 0;
  int  bad = 0;
  int  nwr = 0;
  bq_t dq;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (write_en) begin
          nwr++;
          if (wq.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            e = wq.pop_front();
            chk("waddr", int'(c_waddr), e.addr);
            chk("wdata", int'(dwrite), e.data);
            chk("write_cycle", cyc, e.at);
          end
        end
        if (cpu_start) begin
          if (sq.size() == 0) chk("unexpected_start", 1, 0);
          else begin
            e = sq.pop_front();
            chk("startaddr", int'(startaddr), e.addr);
            chk("start_cycle", cyc, e.at);
          end
        end
`ifdef LOADER_ACK_EN
        if (transmit) begin
          if (txq.size() == 0) chk("unexpected_tx", 1, 0);
          else chk("tx_byte", int'(tx_byte), txq.pop_front());
        end
`endif
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind: 0 = no output expected, 1 = RAM write at address a, 2 = CPU start at address a
  task automatic send_byte(input logic [7:0] b, input int kind, input int a);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    if (kind == 1) wq.push_back('{a, int'(b), cyc + 1});
    if (kind == 2) sq.push_back('{a, 0, cyc + 1});
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic exp_ack(input bit good);
`ifdef LOADER_ACK_EN
    txq.push_back(good ? 32'h4B : 32'h45);
`else
    if (good) begin end
`endif
  endtask

  task automatic send_load(input int ah, input int al, input int len, input bq_t d, input int cs);
    int a;
    int s;
    a = ((ah & 1) << 8) | al;
    s = 0;
    foreach (d[i]) s += int'(d[i]);
    exp_ack((s & 255) == cs);
    send_byte(8'h4C, 0, 0);
    send_byte(8'(ah), 0, 0);
    send_byte(8'(al), 0, 0);
    send_byte(8'(len), 0, 0);
    foreach (d[i]) send_byte(d[i], 1, (a + i) % 512);
    send_byte(8'(cs), 0, 0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // reset state
    wait_cycles(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_we", int'(write_en), 0);
    chk("rst_start", int'(cpu_start), 0);
    chk("rst_startaddr", int'(startaddr), 0);
    chk("rst_waddr", int'(c_waddr), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);

    // basic load: AA BB CC at 0x010, CS 0x31
    dq.delete(); dq.push_back(8'hAA); dq.push_back(8'hBB); dq.push_back(8'hCC);
    send_load(8'h00, 8'h10, 3, dq, 8'h31);
    wait_cycles(2);
    chk("load1_busy", int'(busy), 0);
    chk("load1_err", int'(err), 0);

    // address wrap 0x1FE..0x001
    dq.delete(); dq.push_back(8'h01); dq.push_back(8'h02); dq.push_back(8'h03); dq.push_back(8'h04);
    send_load(8'h01, 8'hFE, 4, dq, 8'h0A);
    wait_cycles(2);
    chk("wrap_err", int'(err), 0);

    // LEN=0 -> 256 bytes at 0x100 (AH=0x03: upper bits ignored), sum 0..255 = 0x80
    dq.delete();
    for (int i = 0; i < 256; i++) dq.push_back(8'(i));
    send_load(8'h03, 8'h00, 0, dq, 8'h80);
    wait_cycles(2);
    chk("len256_err", int'(err), 0);
    chk("len256_busy", int'(busy), 0);

    // bad checksum: bytes still written, err set
    dq.delete(); dq.push_back(8'h11); dq.push_back(8'h22);
    send_load(8'h00, 8'h40, 2, dq, 8'h00);
    wait_cycles(2);
    chk("badcs_err", int'(err), 1);

    // junk byte in IDLE is ignored and leaves err alone
    send_byte(8'h12, 0, 0);
    chk("junk_busy", int'(busy), 0);
    chk("junk_err", int'(err), 1);

    // command byte clears err; finish a one-byte frame 0x55 at 0x000
    send_byte(8'h4C, 0, 0);
    chk("cmd_clears_err", int'(err), 0);
    chk("cmd_busy", int'(busy), 1);
    exp_ack(1'b1);
    send_byte(8'h00, 0, 0);
    send_byte(8'h00, 0, 0);
    send_byte(8'h01, 0, 0);
    send_byte(8'h55, 1, 0);
    send_byte(8'h55, 0, 0);
    wait_cycles(2);
    chk("len1_err", int'(err), 0);

    // GO with CPU halted
    cpu_busy = 1'b0;
    exp_ack(1'b1);
    send_byte(8'h47, 0, 0);
    send_byte(8'h01, 0, 0);
    send_byte(8'h23, 2, 9'h123);
    wait_cycles(2);
    chk("go_startaddr", int'(startaddr), 9'h123);
    chk("go_err", int'(err), 0);

    // GO while CPU runs: no start, startaddr held, err
    cpu_busy = 1'b1;
    exp_ack(1'b0);
    send_byte(8'h47, 0, 0);
    send_byte(8'h00, 0, 0);
    send_byte(8'h45, 0, 0);
    wait_cycles(2);
    cpu_busy = 1'b0;
    chk("gobusy_startaddr", int'(startaddr), 9'h123);
    chk("gobusy_err", int'(err), 1);

    // timeout after a partial frame
    send_byte(8'h4C, 0, 0);
    chk("tmo_err_cleared", int'(err), 0);
    send_byte(8'h00, 0, 0);
    wait_cycles(8);
    chk("tmo_still_busy", int'(busy), 1);
    wait_cycles(TMO + 2);
    chk("tmo_busy", int'(busy), 0);
    chk("tmo_err", int'(err), 1);

    // asynchronous reset in the middle of DATA
    send_byte(8'h4C, 0, 0);
    send_byte(8'h00, 0, 0);
    send_byte(8'h00, 0, 0);
    send_byte(8'h05, 0, 0);
    send_byte(8'h11, 1, 0);
    send_byte(8'h22, 1, 1);
    @(negedge clk);
    rx_byte  = 8'h33;
    rx_valid = 1'b1;
    @(posedge clk);
    #2;
    chk("pre_rst_we", int'(write_en), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_we", int'(write_en), 0);
    chk("arst_waddr", int'(c_waddr), 0);
    chk("arst_wdata", int'(dwrite), 0);
    chk("arst_startaddr", int'(startaddr), 0);
    chk("arst_err", int'(err), 0);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);
    chk("post_rst_busy", int'(busy), 0);

`ifdef LOADER_ACK_EN
    // ack held off while the transmitter is busy
    is_transmitting = 1'b1;
    dq.delete(); dq.push_back(8'h77);
    send_load(8'h00, 8'h20, 1, dq, 8'h77);
    wait_cycles(6);
    chk("ack_held_pending", txq.size(), 1);
    chk("ack_held_busy", int'(busy), 1);
    is_transmitting = 1'b0;
    wait_cycles(3);
    chk("ack_sent", txq.size(), 0);
    chk("ack_idle", int'(busy), 0);
    dq.delete(); dq.push_back(8'h77);
    send_load(8'h00, 8'h20, 1, dq, 8'h00);
    wait_cycles(3);
    chk("nak_sent", txq.size(), 0);
    chk("nak_err", int'(err), 1);
`endif

    wait_cycles(3);
    chk("writes_pending", wq.size(), 0);
    chk("starts_pending", sq.size(), 0);
`ifdef LOADER_ACK_EN
    chk("write_count", nwr, 270);
`else
    chk("write_count", nwr, 268);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
